// File: rtl/axil_stream_reader_pkg.sv
// rtl/axil_stream_reader_pkg.sv - shared types and constants for the AXI-Lite stream reader
//
// Purpose: FSM state encoding, the OKAY response code and the address-step
// derivation shared by axil_stream_reader and its testbench.
// Ports: none (package).

package axil_stream_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Byte step between consecutive word reads; rounded up to a power of two so
  // that the alignment mask derived from it is always a clean low-bit mask.
  function automatic int unsigned addr_step(input int unsigned strb_width);
    return (strb_width > 1) ? (1 << $clog2(strb_width)) : 1;
  endfunction

endpackage

// File: rtl/axil_rd_fifo.sv
// rtl/axil_rd_fifo.sv - synchronous response FIFO with registered output and occupancy count
//
// Purpose: buffers R-channel words for the stream side. Head word comes from a
// storage register, so a word pushed in cycle M is visible from cycle M+1.
// Ports:
//   clk, rst  - clock, synchronous active-high reset (flushes pointers/count)
//   push/wdata - write one word (ignored when full unless popping the same cycle)
//   pop        - remove head word (ignored when empty)
//   rdata      - head word, stable until popped
//   empty      - no words held
//   count      - words held, clog2(DEPTH)+1 bits

module axil_rd_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != FULL_COUNT) || do_pop);
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the flushed pointers/count make old contents invisible.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/axil_stream_reader.sv
// rtl/axil_stream_reader.sv - AXI-Lite sequential read master feeding an AXI-Stream
//
// Purpose: accepts (cmd_addr, cmd_len) and issues cmd_len+1 single-beat reads at
// word-aligned, wrapping addresses, keeping at most FIFO_DEPTH reads in flight
// or buffered; returned words leave on m_axis_* with tlast on the final word.
// Optional macro AXIL_STREAM_READER_TUSER_EN adds m_axis_tuser carrying a
// per-word "rresp was not OKAY" flag aligned with tdata.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   cmd_addr/len/valid/ready - command (byte address, word count minus 1)
//   m_axil_ar*               - read address channel (arprot fixed 3'b000)
//   m_axil_r*                - read data channel (rready always high)
//   m_axis_t*                - output stream
//   busy                     - FSM not IDLE
//   done                     - one-cycle pulse when the command has fully streamed
//   err                      - sticky non-OKAY response since the last command accept

module axil_stream_reader
  import axil_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int LEN_WIDTH  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  busy,
  output logic                  done,
  output logic                  err
`ifdef AXIL_STREAM_READER_TUSER_EN
  ,
  output logic                  m_axis_tuser
`endif
);

  localparam int CNTW = $clog2(FIFO_DEPTH) + 1;
  localparam int LENW = LEN_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_INC   = ADDR_WIDTH'(addr_step(STRB_WIDTH));
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_INC - ADDR_WIDTH'(1));
  localparam logic [CNTW:0]         CREDIT_MAX = (CNTW + 1)'(FIFO_DEPTH);
`ifdef AXIL_STREAM_READER_TUSER_EN
  localparam int FW = DATA_WIDTH + 1;
`else
  localparam int FW = DATA_WIDTH;
`endif

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LENW-1:0]       issue_cnt_q, issue_cnt_d;
  logic [LENW-1:0]       out_cnt_q, out_cnt_d;
  logic [CNTW-1:0]       inflight_q, inflight_d;
  logic                  err_q, err_d;
  logic                  arvalid_q, arvalid_d;

  logic                  accept, ar_hs, push, pop, tvalid, credit_ok;
  logic [CNTW-1:0]       fifo_count, fifo_count_d;
  logic [CNTW:0]         credit_used;
  logic                  fifo_empty;
  logic [FW-1:0]         fifo_wdata, fifo_rdata;

`ifdef AXIL_STREAM_READER_TUSER_EN
  assign fifo_wdata = {m_axil_rresp != RESP_OKAY, m_axil_rdata};
`else
  assign fifo_wdata = m_axil_rdata;
`endif

  axil_rd_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (fifo_wdata),
    .pop   (pop),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Handshake terms are masked during reset so nothing moves in that cycle.
  assign cmd_ready = !rst && (state_q == IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign ar_hs     = m_axil_arvalid && m_axil_arready;
  // Beats with nothing outstanding are stale (e.g. issued before a reset) and dropped.
  assign push      = m_axil_rvalid && (inflight_q != '0);
  assign tvalid    = !rst && !fifo_empty;
  assign pop       = tvalid && m_axis_tready;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    issue_cnt_d = issue_cnt_q;
    out_cnt_d   = out_cnt_q;
    err_d       = err_q;
    inflight_d  = inflight_q + CNTW'(ar_hs) - CNTW'(push);

    if (push && (m_axil_rresp != RESP_OKAY)) begin
      err_d = 1'b1;
    end
    if (pop) begin
      out_cnt_d = out_cnt_q - LENW'(1);
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d      = cmd_addr & ALIGN_MASK;
          issue_cnt_d = {1'b0, cmd_len} + LENW'(1);
          out_cnt_d   = {1'b0, cmd_len} + LENW'(1);
          err_d       = 1'b0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (ar_hs) begin
          addr_d      = addr_q + ADDR_INC;
          issue_cnt_d = issue_cnt_q - LENW'(1);
          if (issue_cnt_q == LENW'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (out_cnt_q == '0) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Credit is judged on next-cycle occupancy so a newly raised arvalid can
    // never push reads-in-flight plus buffered words past FIFO_DEPTH.
    fifo_count_d = fifo_count + CNTW'(push) - CNTW'(pop);
    credit_used  = {1'b0, inflight_d} + {1'b0, fifo_count_d};
    credit_ok    = credit_used < CREDIT_MAX;

    if (m_axil_arvalid && !m_axil_arready) begin
      arvalid_d = 1'b1;
    end else begin
      arvalid_d = (state_d == ISSUE) && (issue_cnt_d != '0) && credit_ok;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      issue_cnt_q <= '0;
      out_cnt_q   <= '0;
      inflight_q  <= '0;
      err_q       <= 1'b0;
      arvalid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      issue_cnt_q <= issue_cnt_d;
      out_cnt_q   <= out_cnt_d;
      inflight_q  <= inflight_d;
      err_q       <= err_d;
      arvalid_q   <= arvalid_d;
    end
  end

  assign m_axil_araddr  = addr_q;
  assign m_axil_arprot  = 3'b000;
  assign m_axil_arvalid = arvalid_q && !rst;
  assign m_axil_rready  = 1'b1;
  assign m_axis_tdata   = fifo_rdata[DATA_WIDTH-1:0];
  assign m_axis_tvalid  = tvalid;
  assign m_axis_tlast   = tvalid && (out_cnt_q == LENW'(1));
  assign busy           = !rst && (state_q != IDLE);
  assign done           = !rst && (state_q == DRAIN) && (out_cnt_q == '0);
  assign err            = err_q;
`ifdef AXIL_STREAM_READER_TUSER_EN
  assign m_axis_tuser   = fifo_rdata[DATA_WIDTH];
`endif

endmodule

// File: tb/tb_axil_stream_reader.sv
// tb/tb_axil_stream_reader.sv - directed self-checking bench for axil_stream_reader

module tb_axil_stream_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [8:0]  cmd_addr = '0;
  logic [7:0]  cmd_len = '0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [8:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;
  logic        busy, done, err;
`ifdef AXIL_STREAM_READER_TUSER_EN
  logic        tuser;
`endif

  always #5 clk = ~clk;

  axil_stream_reader dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_addr       (cmd_addr),
    .cmd_len        (cmd_len),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .m_axil_araddr  (araddr),
    .m_axil_arprot  (arprot),
    .m_axil_arvalid (arvalid),
    .m_axil_arready (arready),
    .m_axil_rdata   (rdata),
    .m_axil_rresp   (rresp),
    .m_axil_rvalid  (rvalid),
    .m_axil_rready  (rready),
    .m_axis_tdata   (tdata),
    .m_axis_tvalid  (tvalid),
    .m_axis_tready  (tready),
    .m_axis_tlast   (tlast),
    .busy           (busy),
    .done           (done),
    .err            (err)
`ifdef AXIL_STREAM_READER_TUSER_EN
    ,
    .m_axis_tuser   (tuser)
`endif
  );

  int compared = 0;
  int mismatched = 0;

  // Controls written only by the test sequence.
  int tready_mode = 0;
  int err_beat = -1;
  int stall_target = 0;

  // Logs written only by the environment process.
  logic [31:0] mem [128];
  logic [8:0]  rq [$];
  logic [31:0] rx_data [$];
  logic        rx_last [$];
  logic        rx_user [$];
  logic [8:0]  ar_log [$];
  int ar_total = 0, tx_total = 0, r_total = 0, done_cnt = 0;
  int stall_seen = 0, stab_bad = 0, max_out = 0;

  // BRAM slave (1-cycle read latency), stream sink and monitors.
  initial begin
    logic ar_hs, r_hs, t_hs, stall_prev;
    logic [8:0] ar_a, stall_addr;
    for (int i = 0; i < 128; i++) mem[i] = 32'hA0 + i;
    arready = 1'b1; rvalid = 1'b0; rdata = '0; rresp = 2'b00; tready = 1'b1;
    stall_prev = 1'b0; stall_addr = '0;
    forever begin
      @(negedge clk);
      ar_hs = arvalid && arready;
      ar_a  = araddr;
      r_hs  = rvalid && rready;
      t_hs  = tvalid && tready;
      if (t_hs) begin
        rx_data.push_back(tdata);
        rx_last.push_back(tlast);
`ifdef AXIL_STREAM_READER_TUSER_EN
        rx_user.push_back(tuser);
`else
        rx_user.push_back(1'b0);
`endif
        tx_total++;
      end
      if (done) done_cnt++;
      if (stall_prev && (!arvalid || araddr != stall_addr)) stab_bad++;
      if (arvalid && !arready) stall_seen++;
      stall_prev = arvalid && !arready;
      stall_addr = araddr;
      if (ar_hs) begin
        ar_log.push_back(ar_a);
        ar_total++;
      end
      if (ar_total - tx_total > max_out) max_out = ar_total - tx_total;
      @(posedge clk);
      #1;
      if (r_hs) begin
        void'(rq.pop_front());
        r_total++;
      end
      if (ar_hs) rq.push_back(ar_a);
      rvalid = (rq.size() != 0);
      rdata  = rvalid ? mem[rq[0][8:2]] : 32'h0;
      rresp  = (rvalid && r_total == err_beat) ? 2'b10 : 2'b00;
      arready = (stall_seen >= stall_target);
      tready  = (tready_mode != 0) ? ~tready : 1'b1;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic run_cmd(input logic [8:0] a, input logic [7:0] l);
    bit ok = 0;
    @(posedge clk); #1;
    cmd_addr = a; cmd_len = l; cmd_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    compared++;
    if (!ok) begin mismatched++; $display("FAIL cmd_accept: cmd_ready never seen, required 1"); end
  endtask

  task automatic wait_done(input int base);
    bit ok = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (done_cnt != base) begin ok = 1; break; end
    end
    repeat (3) @(negedge clk);
    compared++;
    if (!ok) begin mismatched++; $display("FAIL done_timeout: no done pulse, required 1"); end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    compared += 6;
    if (cmd_ready !== 1'b0) begin mismatched++; $display("FAIL rst_cmd_ready: got %b required 0", cmd_ready); end
    if (arvalid !== 1'b0)   begin mismatched++; $display("FAIL rst_arvalid: got %b required 0", arvalid); end
    if (tvalid !== 1'b0)    begin mismatched++; $display("FAIL rst_tvalid: got %b required 0", tvalid); end
    if (busy !== 1'b0)      begin mismatched++; $display("FAIL rst_busy: got %b required 0", busy); end
    if (done !== 1'b0)      begin mismatched++; $display("FAIL rst_done: got %b required 0", done); end
    if (err !== 1'b0)       begin mismatched++; $display("FAIL rst_err: got %b required 0", err); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    compared += 2;
    if (cmd_ready !== 1'b1) begin mismatched++; $display("FAIL post_rst_cmd_ready: got %b required 1", cmd_ready); end
    if (arprot !== 3'b000)  begin mismatched++; $display("FAIL arprot: got %b required 000", arprot); end
  endtask

  task automatic test_basic;
    int b = rx_data.size();
    int bd = done_cnt;
    run_cmd(9'h000, 8'd7);
    @(negedge clk);
    compared += 2;
    if (arvalid !== 1'b1) begin mismatched++; $display("FAIL basic_first_arvalid: got %b required 1", arvalid); end
    if (busy !== 1'b1)    begin mismatched++; $display("FAIL basic_busy: got %b required 1", busy); end
    wait_done(bd);
    compared += 4;
    if (rx_data.size() - b != 8) begin mismatched++; $display("FAIL basic_count: got %0d required 8", rx_data.size() - b); end
    if (done_cnt - bd != 1)      begin mismatched++; $display("FAIL basic_done_pulses: got %0d required 1", done_cnt - bd); end
    if (err !== 1'b0)            begin mismatched++; $display("FAIL basic_err: got %b required 0", err); end
    if (busy !== 1'b0)           begin mismatched++; $display("FAIL basic_idle: got %b required 0", busy); end
    for (int i = 0; i < 8 && b + i < rx_data.size(); i++) begin
      compared += 2;
      if (rx_data[b+i] !== 32'hA0 + i) begin mismatched++; $display("FAIL basic_data[%0d]: got %h required %h", i, rx_data[b+i], 32'hA0 + i); end
      if (rx_last[b+i] !== (i == 7))   begin mismatched++; $display("FAIL basic_tlast[%0d]: got %b required %b", i, rx_last[b+i], i == 7); end
    end
  endtask

  task automatic test_backpressure;
    int b = rx_data.size();
    int bd = done_cnt;
    tready_mode = 1;
    run_cmd(9'h000, 8'd7);
    wait_done(bd);
    tready_mode = 0;
    repeat (2) @(negedge clk);
    compared += 3;
    if (rx_data.size() - b != 8) begin mismatched++; $display("FAIL bp_count: got %0d required 8", rx_data.size() - b); end
    if (max_out > 4 || max_out < 1) begin mismatched++; $display("FAIL bp_outstanding: got %0d required 1..4", max_out); end
    if (done_cnt - bd != 1)      begin mismatched++; $display("FAIL bp_done_pulses: got %0d required 1", done_cnt - bd); end
    for (int i = 0; i < 8 && b + i < rx_data.size(); i++) begin
      compared += 2;
      if (rx_data[b+i] !== 32'hA0 + i) begin mismatched++; $display("FAIL bp_data[%0d]: got %h required %h", i, rx_data[b+i], 32'hA0 + i); end
      if (rx_last[b+i] !== (i == 7))   begin mismatched++; $display("FAIL bp_tlast[%0d]: got %b required %b", i, rx_last[b+i], i == 7); end
    end
  endtask

  task automatic test_wrap;
    logic [8:0]  exp_a [4];
    logic [31:0] exp_d [4];
    int b = rx_data.size();
    int ba = ar_log.size();
    int bd = done_cnt;
    exp_a[0] = 9'h1F8; exp_a[1] = 9'h1FC; exp_a[2] = 9'h000; exp_a[3] = 9'h004;
    exp_d[0] = 32'h11E; exp_d[1] = 32'h11F; exp_d[2] = 32'hA0; exp_d[3] = 32'hA1;
    run_cmd(9'h1F8, 8'd3);
    wait_done(bd);
    compared += 2;
    if (ar_log.size() - ba != 4) begin mismatched++; $display("FAIL wrap_ar_count: got %0d required 4", ar_log.size() - ba); end
    if (rx_data.size() - b != 4) begin mismatched++; $display("FAIL wrap_count: got %0d required 4", rx_data.size() - b); end
    for (int i = 0; i < 4 && ba + i < ar_log.size() && b + i < rx_data.size(); i++) begin
      compared += 3;
      if (ar_log[ba+i] !== exp_a[i])  begin mismatched++; $display("FAIL wrap_araddr[%0d]: got %h required %h", i, ar_log[ba+i], exp_a[i]); end
      if (rx_data[b+i] !== exp_d[i])  begin mismatched++; $display("FAIL wrap_data[%0d]: got %h required %h", i, rx_data[b+i], exp_d[i]); end
      if (rx_last[b+i] !== (i == 3))  begin mismatched++; $display("FAIL wrap_tlast[%0d]: got %b required %b", i, rx_last[b+i], i == 3); end
    end
  endtask

  task automatic test_err;
    int b = rx_data.size();
    int bd = done_cnt;
    err_beat = r_total + 1;
    run_cmd(9'h010, 8'd3);
    wait_done(bd);
    compared += 2;
    if (err !== 1'b1)            begin mismatched++; $display("FAIL err_sticky: got %b required 1", err); end
    if (rx_data.size() - b != 4) begin mismatched++; $display("FAIL err_count: got %0d required 4", rx_data.size() - b); end
    for (int i = 0; i < 4 && b + i < rx_data.size(); i++) begin
      compared++;
      if (rx_data[b+i] !== 32'hA4 + i) begin mismatched++; $display("FAIL err_data[%0d]: got %h required %h", i, rx_data[b+i], 32'hA4 + i); end
`ifdef AXIL_STREAM_READER_TUSER_EN
      compared++;
      if (rx_user[b+i] !== (i == 1)) begin mismatched++; $display("FAIL err_tuser[%0d]: got %b required %b", i, rx_user[b+i], i == 1); end
`endif
    end
    err_beat = -1;
    b = rx_data.size();
    bd = done_cnt;
    run_cmd(9'h000, 8'd0);
    @(negedge clk);
    compared++;
    if (err !== 1'b0) begin mismatched++; $display("FAIL err_clear_on_accept: got %b required 0", err); end
    wait_done(bd);
    compared += 3;
    if (err !== 1'b0)            begin mismatched++; $display("FAIL err_after_clean: got %b required 0", err); end
    if (rx_data.size() - b != 1) begin mismatched++; $display("FAIL err_next_count: got %0d required 1", rx_data.size() - b); end
    else if (rx_data[b] !== 32'hA0) begin mismatched++; $display("FAIL err_next_data: got %h required a0", rx_data[b]); end
  endtask

  task automatic test_stall;
    int b = rx_data.size();
    int bd = done_cnt;
    int bs = stall_seen;
    int ba = ar_log.size();
    stall_target = stall_seen + 5;
    run_cmd(9'h040, 8'd0);
    wait_done(bd);
    compared += 4;
    if (stall_seen - bs != 5)    begin mismatched++; $display("FAIL stall_cycles: got %0d required 5", stall_seen - bs); end
    if (stab_bad != 0)           begin mismatched++; $display("FAIL stall_stability: got %0d changes required 0", stab_bad); end
    if (ar_log.size() - ba != 1) begin mismatched++; $display("FAIL stall_ar_count: got %0d required 1", ar_log.size() - ba); end
    else if (ar_log[ba] !== 9'h040) begin mismatched++; $display("FAIL stall_araddr: got %h required 040", ar_log[ba]); end
    if (rx_data.size() - b != 1) begin mismatched++; $display("FAIL single_count: got %0d required 1", rx_data.size() - b); end
    else begin
      compared += 2;
      if (rx_data[b] !== 32'hB0) begin mismatched++; $display("FAIL single_data: got %h required b0", rx_data[b]); end
      if (rx_last[b] !== 1'b1)   begin mismatched++; $display("FAIL single_tlast: got %b required 1", rx_last[b]); end
    end
  endtask

  task automatic test_reset_mid;
    int b = rx_data.size();
    int bd = done_cnt;
    int b2;
    bit ok = 0;
    run_cmd(9'h000, 8'd7);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rx_data.size() - b >= 3) begin ok = 1; break; end
    end
    compared++;
    if (!ok) begin mismatched++; $display("FAIL mid_progress: got %0d beats required 3", rx_data.size() - b); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    compared += 7;
    if (arvalid !== 1'b0)   begin mismatched++; $display("FAIL mid_arvalid: got %b required 0", arvalid); end
    if (tvalid !== 1'b0)    begin mismatched++; $display("FAIL mid_tvalid: got %b required 0", tvalid); end
    if (tlast !== 1'b0)     begin mismatched++; $display("FAIL mid_tlast: got %b required 0", tlast); end
    if (busy !== 1'b0)      begin mismatched++; $display("FAIL mid_busy: got %b required 0", busy); end
    if (done !== 1'b0)      begin mismatched++; $display("FAIL mid_done: got %b required 0", done); end
    if (err !== 1'b0)       begin mismatched++; $display("FAIL mid_err: got %b required 0", err); end
    if (cmd_ready !== 1'b1) begin mismatched++; $display("FAIL mid_cmd_ready: got %b required 1", cmd_ready); end
    repeat (10) @(negedge clk);
    compared += 2;
    if (done_cnt != bd) begin mismatched++; $display("FAIL mid_no_done: got %0d pulses required 0", done_cnt - bd); end
    if (rx_data.size() - b > 4) begin mismatched++; $display("FAIL mid_beats: got %0d required at most 4", rx_data.size() - b); end
    for (int i = b; i < rx_data.size(); i++) begin
      compared++;
      if (rx_last[i] !== 1'b0) begin mismatched++; $display("FAIL mid_partial_tlast[%0d]: got %b required 0", i - b, rx_last[i]); end
    end
    b2 = rx_data.size();
    bd = done_cnt;
    run_cmd(9'h020, 8'd1);
    wait_done(bd);
    compared++;
    if (rx_data.size() - b2 != 2) begin mismatched++; $display("FAIL after_rst_count: got %0d required 2", rx_data.size() - b2); end
    for (int i = 0; i < 2 && b2 + i < rx_data.size(); i++) begin
      compared += 2;
      if (rx_data[b2+i] !== 32'hA8 + i) begin mismatched++; $display("FAIL after_rst_data[%0d]: got %h required %h", i, rx_data[b2+i], 32'hA8 + i); end
      if (rx_last[b2+i] !== (i == 1))   begin mismatched++; $display("FAIL after_rst_tlast[%0d]: got %b required %b", i, rx_last[b2+i], i == 1); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_err();
    test_stall();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
